corner_addr_collector: RTL and testbench

Raster-scan front end of the feature-point register file. It consumes the per-pixel FAST9 corner decision stream, computes each pixel's linear image address, and writes the addresses of up to 16 accepted corners into consecutive slots of the 16×15-bit address register downstream via `refAddr`/`posAddr`. At end of frame it raises `posReaden` so the register file presents its 240-bit `position` bus and `isMatching` to the matching stage.

---
 rtl/fast9_pkg.sv | 17 +
 rtl/corner_addr_collector_raster_counter.sv | 58 +++++
 rtl/corner_addr_collector.sv | 144 ++++++++++++++
 tb/tb_corner_addr_collector.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fast9_pkg.sv
// Shared defaults and FSM encoding for the FAST9 corner address collector.
package fast9_pkg;

  localparam int IMG_W_DEF   = 160;
  localparam int IMG_H_DEF   = 120;
  localparam int ADDR_W_DEF  = 15;
  localparam int MAX_PTS_DEF = 16;
  localparam int BORDER_DEF  = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } collect_state_t;

endpackage

// File: rtl/corner_addr_collector_raster_counter.sv
// Raster x/y position of the current pixel, with border and last-pixel flags.
module raster_counter #(
  parameter int IMG_W  = 160,
  parameter int IMG_H  = 120,
  parameter int BORDER = 3,
  parameter int X_W    = 8,
  parameter int Y_W    = 7
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           clear,
  input  logic           advance,
  output logic [X_W-1:0] x,
  output logic [Y_W-1:0] y,
  output logic           inBorder,
  output logic           lastPix
);

  logic [X_W-1:0] x_q, x_d;
  logic [Y_W-1:0] y_q, y_d;
  logic           x_end, y_end;

  assign x_end = (x_q == X_W'(IMG_W - 1));
  assign y_end = (y_q == Y_W'(IMG_H - 1));

  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (clear) begin
      x_d = '0;
      y_d = '0;
    end else if (advance) begin
      if (x_end) begin
        x_d = '0;
        y_d = y_end ? '0 : y_q + 1'b1;
      end else begin
        x_d = x_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

  assign x        = x_q;
  assign y        = y_q;
  assign lastPix  = x_end && y_end;
  assign inBorder = (x_q >= X_W'(BORDER)) && (x_q <= X_W'(IMG_W - 1 - BORDER)) &&
                    (y_q >= Y_W'(BORDER)) && (y_q <= Y_W'(IMG_H - 1 - BORDER));

endmodule

// File: rtl/corner_addr_collector.sv
// Collects linear addresses of up to MAX_PTS border-qualified FAST9 corners per frame
// and hands them to the feature-point register file.
//
// state | meaning
// IDLE  | after reset, waiting for frameStart
// SCAN  | accepting pixels, writing corner addresses
// FLUSH | last pixel's write on the bus, readout next cycle
// DONE  | address set complete, posReaden held
module corner_addr_collector
  import fast9_pkg::*;
#(
  parameter int IMG_W   = IMG_W_DEF,
  parameter int IMG_H   = IMG_H_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int MAX_PTS = MAX_PTS_DEF,
  parameter int BORDER  = BORDER_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              frameStart,
  input  logic              pixValid,
  input  logic              isCorner,
  output logic [ADDR_W-1:0] refAddr,
  output logic [3:0]        posAddr,
  output logic              posWe,
  output logic              posReaden,
  output logic [4:0]        pointCount,
  output logic              frameDone,
  output logic              overflow
);

  localparam int X_W = $clog2(IMG_W);
  localparam int Y_W = $clog2(IMG_H);

  collect_state_t    state_q, state_d;
  logic [ADDR_W-1:0] ref_addr_q, ref_addr_d;
  logic [3:0]        pos_addr_q, pos_addr_d;
  logic              pos_we_q, pos_we_d;
  logic              readen_q, readen_d;
  logic [4:0]        count_q, count_d;
  logic              done_q, done_d;
  logic              ovf_q, ovf_d;

  logic [X_W-1:0]    pix_x;
  logic [Y_W-1:0]    pix_y;
  logic              in_border, last_pix, advance;
  logic [ADDR_W-1:0] pix_addr;

  assign advance = (state_q == ST_SCAN) && pixValid && !frameStart;

  raster_counter #(
    .IMG_W  (IMG_W),
    .IMG_H  (IMG_H),
    .BORDER (BORDER),
    .X_W    (X_W),
    .Y_W    (Y_W)
  ) u_raster (
    .clk      (clk),
    .reset    (reset),
    .clear    (frameStart),
    .advance  (advance),
    .x        (pix_x),
    .y        (pix_y),
    .inBorder (in_border),
    .lastPix  (last_pix)
  );

  assign pix_addr = ADDR_W'(pix_y) * ADDR_W'(IMG_W) + ADDR_W'(pix_x);

  always_comb begin
    state_d    = state_q;
    ref_addr_d = ref_addr_q;
    pos_addr_d = pos_addr_q;
    pos_we_d   = 1'b0;
    readen_d   = readen_q;
    count_d    = count_q;
    done_d     = 1'b0;
    ovf_d      = ovf_q;
    if (frameStart) begin
      state_d  = ST_SCAN;
      count_d  = '0;
      ovf_d    = 1'b0;
      readen_d = 1'b0;
    end else begin
      case (state_q)
        ST_SCAN: begin
          if (pixValid) begin
            if (isCorner && in_border) begin
              if (count_q < 5'(MAX_PTS)) begin
                pos_we_d   = 1'b1;
                ref_addr_d = pix_addr;
                pos_addr_d = count_q[3:0];
                count_d    = count_q + 1'b1;
              end else begin
                ovf_d = 1'b1;
              end
            end
            if (last_pix) state_d = ST_FLUSH;
          end
        end
        // one spare cycle so the final slot write lands before readout
        ST_FLUSH: begin
          state_d  = ST_DONE;
          readen_d = 1'b1;
          done_d   = 1'b1;
        end
        ST_DONE: state_d = ST_DONE;
        ST_IDLE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      ref_addr_q <= '0;
      pos_addr_q <= '0;
      pos_we_q   <= 1'b0;
      readen_q   <= 1'b0;
      count_q    <= '0;
      done_q     <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      ref_addr_q <= ref_addr_d;
      pos_addr_q <= pos_addr_d;
      pos_we_q   <= pos_we_d;
      readen_q   <= readen_d;
      count_q    <= count_d;
      done_q     <= done_d;
      ovf_q      <= ovf_d;
    end
  end

  assign refAddr    = ref_addr_q;
  assign posAddr    = pos_addr_q;
  assign posWe      = pos_we_q;
  assign posReaden  = readen_q;
  assign pointCount = count_q;
  assign frameDone  = done_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_corner_addr_collector.sv
// Directed bench for corner_addr_collector at the default 160x120 geometry.
module tb_corner_addr_collector;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        frameStart = 1'b0;
  logic        pixValid = 1'b0;
  logic        isCorner = 1'b0;
  logic [14:0] refAddr;
  logic [3:0]  posAddr;
  logic        posWe, posReaden, frameDone, overflow;
  logic [4:0]  pointCount;

  int n_checks = 0;
  int n_fail   = 0;
  int fd_cnt   = 0;
  int wr_ref[$];
  int wr_pos[$];
  bit corner_map[int];

  localparam int LAST = 160 * 120 - 1;

  always #5 clk = ~clk;

  corner_addr_collector dut (
    .clk        (clk),
    .reset      (reset),
    .frameStart (frameStart),
    .pixValid   (pixValid),
    .isCorner   (isCorner),
    .refAddr    (refAddr),
    .posAddr    (posAddr),
    .posWe      (posWe),
    .posReaden  (posReaden),
    .pointCount (pointCount),
    .frameDone  (frameDone),
    .overflow   (overflow)
  );

  always @(negedge clk) begin
    if (posWe) begin
      wr_ref.push_back(int'(refAddr));
      wr_pos.push_back(int'(posAddr));
    end
    if (frameDone) fd_cnt++;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // off-cycles drive isCorner high to show it is qualified by pixValid
  task automatic send_pix(input bit c, input int gap);
    pixValid = 1'b1;
    isCorner = c;
    tick();
    pixValid = 1'b0;
    isCorner = (gap != 0);
    repeat (gap) tick();
    isCorner = 1'b0;
  endtask

  task automatic run_pixels(input int lo, input int hi, input int gap);
    for (int p = lo; p <= hi; p++) send_pix(corner_map.exists(p) != 0, (p == hi) ? 0 : gap);
  endtask

  task automatic start_frame;
    frameStart = 1'b1;
    tick();
    frameStart = 1'b0;
    wr_ref.delete();
    wr_pos.delete();
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) tick();
    n_checks++;
    if ({refAddr, posAddr, posWe, posReaden, pointCount, frameDone, overflow} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got ref=%0d pos=%0d we=%0b rd=%0b cnt=%0d fd=%0b ovf=%0b, expected all 0",
               refAddr, posAddr, posWe, posReaden, pointCount, frameDone, overflow);
    end
    reset = 1'b0;
    wr_ref.delete();
    wr_pos.delete();
    for (int i = 0; i < 5; i++) send_pix(1'b1, 0);
    tick();
    n_checks++;
    if (wr_ref.size() != 0 || pointCount !== 5'd0) begin
      n_fail++;
      $display("FAIL idle_ignores_pixels: got writes=%0d cnt=%0d, expected 0 and 0", wr_ref.size(), pointCount);
    end
  endtask

  task automatic test_single_corner;
    corner_map.delete();
    corner_map[5 * 160 + 10] = 1'b1;
    start_frame();
    run_pixels(0, 810, 0);
    n_checks++;
    if (posWe !== 1'b1 || refAddr !== 15'd810 || posAddr !== 4'd0 || pointCount !== 5'd1) begin
      n_fail++;
      $display("FAIL single_write: got we=%0b ref=%0d pos=%0d cnt=%0d, expected 1 810 0 1", posWe, refAddr, posAddr, pointCount);
    end
    run_pixels(811, 811, 0);
    n_checks++;
    if (posWe !== 1'b0 || refAddr !== 15'd810 || posAddr !== 4'd0) begin
      n_fail++;
      $display("FAIL single_hold: got we=%0b ref=%0d pos=%0d, expected 0 810 0", posWe, refAddr, posAddr);
    end
    run_pixels(812, LAST, 0);
    n_checks++;
    if (posReaden !== 1'b0 || frameDone !== 1'b0) begin
      n_fail++;
      $display("FAIL single_flush: got rd=%0b fd=%0b, expected 0 0", posReaden, frameDone);
    end
    tick();
    n_checks++;
    if (posReaden !== 1'b1 || frameDone !== 1'b1 || pointCount !== 5'd1) begin
      n_fail++;
      $display("FAIL single_done: got rd=%0b fd=%0b cnt=%0d, expected 1 1 1", posReaden, frameDone, pointCount);
    end
    tick();
    n_checks++;
    if (posReaden !== 1'b1 || frameDone !== 1'b0 || wr_ref.size() != 1) begin
      n_fail++;
      $display("FAIL single_after: got rd=%0b fd=%0b writes=%0d, expected 1 0 1", posReaden, frameDone, wr_ref.size());
    end
  endtask

  task automatic test_border;
    corner_map.delete();
    corner_map[50 * 160 + 2]   = 1'b1;
    corner_map[50 * 160 + 157] = 1'b1;
    corner_map[117 * 160 + 50] = 1'b1;
    start_frame();
    run_pixels(0, LAST, 0);
    tick();
    n_checks++;
    if (posReaden !== 1'b1 || frameDone !== 1'b1 || pointCount !== 5'd0 || wr_ref.size() != 0 || overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL border_reject: got rd=%0b fd=%0b cnt=%0d writes=%0d ovf=%0b, expected 1 1 0 0 0",
               posReaden, frameDone, pointCount, wr_ref.size(), overflow);
    end
  endtask

  task automatic test_overflow;
    corner_map.delete();
    for (int x = 3; x <= 19; x++) corner_map[10 * 160 + x] = 1'b1;
    start_frame();
    run_pixels(0, 1618, 0);
    n_checks++;
    if (overflow !== 1'b0 || pointCount !== 5'd16 || posAddr !== 4'd15 || refAddr !== 15'd1618) begin
      n_fail++;
      $display("FAIL ovf_16th: got ovf=%0b cnt=%0d pos=%0d ref=%0d, expected 0 16 15 1618", overflow, pointCount, posAddr, refAddr);
    end
    run_pixels(1619, 1619, 0);
    n_checks++;
    if (overflow !== 1'b1 || posWe !== 1'b0 || refAddr !== 15'd1618 || pointCount !== 5'd16) begin
      n_fail++;
      $display("FAIL ovf_17th: got ovf=%0b we=%0b ref=%0d cnt=%0d, expected 1 0 1618 16", overflow, posWe, refAddr, pointCount);
    end
    run_pixels(1620, LAST, 0);
    tick();
    n_checks++;
    if (posReaden !== 1'b1 || pointCount !== 5'd16 || overflow !== 1'b1 || wr_ref.size() != 16) begin
      n_fail++;
      $display("FAIL ovf_done: got rd=%0b cnt=%0d ovf=%0b writes=%0d, expected 1 16 1 16", posReaden, pointCount, overflow, wr_ref.size());
    end
    for (int i = 0; i < 16 && i < wr_ref.size(); i++) begin
      n_checks++;
      if (wr_pos[i] != i || wr_ref[i] != 1603 + i) begin
        n_fail++;
        $display("FAIL ovf_write[%0d]: got pos=%0d ref=%0d, expected %0d %0d", i, wr_pos[i], wr_ref[i], i, 1603 + i);
      end
    end
  endtask

  task automatic test_gaps;
    corner_map.delete();
    corner_map[810] = 1'b1;
    corner_map[811] = 1'b1;
    start_frame();
    run_pixels(0, 799, 0);
    run_pixels(800, 819, 2);
    run_pixels(820, LAST - 10, 0);
    run_pixels(LAST - 9, LAST, 2);
    n_checks++;
    if (posReaden !== 1'b0) begin
      n_fail++;
      $display("FAIL gap_flush: got rd=%0b, expected 0", posReaden);
    end
    tick();
    n_checks++;
    if (posReaden !== 1'b1 || frameDone !== 1'b1 || pointCount !== 5'd2) begin
      n_fail++;
      $display("FAIL gap_done: got rd=%0b fd=%0b cnt=%0d, expected 1 1 2", posReaden, frameDone, pointCount);
    end
    n_checks++;
    if (wr_ref.size() != 2 || wr_ref[0] != 810 || wr_ref[1] != 811 || wr_pos[0] != 0 || wr_pos[1] != 1) begin
      n_fail++;
      $display("FAIL gap_writes: got n=%0d first ref/pos=%0d/%0d, expected n=2 810/0 then 811/1",
               wr_ref.size(), (wr_ref.size() > 0) ? wr_ref[0] : -1, (wr_pos.size() > 0) ? wr_pos[0] : -1);
    end
  endtask

  task automatic test_frame_restart;
    corner_map.delete();
    for (int x = 3; x <= 19; x++) corner_map[10 * 160 + x] = 1'b1;
    start_frame();
    run_pixels(0, 4999, 0);
    n_checks++;
    if (overflow !== 1'b1 || pointCount !== 5'd16) begin
      n_fail++;
      $display("FAIL restart_pre: got ovf=%0b cnt=%0d, expected 1 16", overflow, pointCount);
    end
    corner_map.delete();
    corner_map[3 * 160 + 3] = 1'b1;
    frameStart = 1'b1;
    pixValid   = 1'b1;
    isCorner   = 1'b1;
    tick();
    frameStart = 1'b0;
    pixValid   = 1'b0;
    isCorner   = 1'b0;
    wr_ref.delete();
    wr_pos.delete();
    n_checks++;
    if (pointCount !== 5'd0 || overflow !== 1'b0 || posWe !== 1'b0 || posReaden !== 1'b0) begin
      n_fail++;
      $display("FAIL restart_clear: got cnt=%0d ovf=%0b we=%0b rd=%0b, expected 0 0 0 0", pointCount, overflow, posWe, posReaden);
    end
    run_pixels(0, 483, 0);
    n_checks++;
    if (posWe !== 1'b1 || posAddr !== 4'd0 || refAddr !== 15'd483 || pointCount !== 5'd1) begin
      n_fail++;
      $display("FAIL restart_first: got we=%0b pos=%0d ref=%0d cnt=%0d, expected 1 0 483 1", posWe, posAddr, refAddr, pointCount);
    end
  endtask

  task automatic test_reset_mid_scan;
    pixValid = 1'b1;
    isCorner = 1'b1;
    reset    = 1'b1;
    tick();
    reset = 1'b0;
    wr_ref.delete();
    wr_pos.delete();
    n_checks++;
    if ({refAddr, posAddr, posWe, posReaden, pointCount, frameDone, overflow} !== '0) begin
      n_fail++;
      $display("FAIL midreset_outputs: got ref=%0d pos=%0d we=%0b rd=%0b cnt=%0d fd=%0b ovf=%0b, expected all 0",
               refAddr, posAddr, posWe, posReaden, pointCount, frameDone, overflow);
    end
    repeat (20) tick();
    pixValid = 1'b0;
    isCorner = 1'b0;
    tick();
    n_checks++;
    if (wr_ref.size() != 0 || pointCount !== 5'd0 || posReaden !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_idle: got writes=%0d cnt=%0d rd=%0b, expected 0 0 0", wr_ref.size(), pointCount, posReaden);
    end
    corner_map.delete();
    corner_map[3 * 160 + 3] = 1'b1;
    start_frame();
    run_pixels(0, 483, 0);
    n_checks++;
    if (posWe !== 1'b1 || posAddr !== 4'd0 || refAddr !== 15'd483) begin
      n_fail++;
      $display("FAIL midreset_rescan: got we=%0b pos=%0d ref=%0d, expected 1 0 483", posWe, posAddr, refAddr);
    end
  endtask

  initial begin
    test_reset();
    test_single_corner();
    test_border();
    test_overflow();
    test_gaps();
    test_frame_restart();
    test_reset_mid_scan();
    n_checks++;
    if (fd_cnt != 4) begin
      n_fail++;
      $display("FAIL frame_done_count: got %0d, expected 4", fd_cnt);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
